// File: rtl/spi_tft_rx.sv
// spi_tft_rx: SPI slave-side deserializer for the TFT link.
// Oversamples SCK/MOSI/CS with the system clock and assembles WIDTH-bit words.
// Completed words are presented on a valid/ready holding register.
module spi_tft_rx #(
    parameter int WIDTH       = 16,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             spi_sck,
    input  logic             spi_mosi,
    input  logic             spi_cs,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sckSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic [SYNC_STAGES-1:0] r_csSync;
    logic                   r_sckPrev;

    state_t                 r_state;
    state_t                 w_stateNext;

    logic [CNT_W-1:0]       r_bitCnt;
    logic [WIDTH-1:0]       r_shift;

    logic [WIDTH-1:0]       r_rxData;
    logic                   r_rxValid;
    logic                   r_overrun;
    logic                   r_frameErr;

    logic                   w_sck;
    logic                   w_mosi;
    logic                   w_cs;
    logic                   w_sckRise;
    logic                   w_shiftEn;
    logic                   w_csRise;
    logic                   w_wordDone;
    logic [WIDTH-1:0]       w_word;

    // Synchronize all three link inputs through equal-depth chains and keep the previous sck
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sckSync  <= '0;
            r_mosiSync <= '0;
            r_csSync   <= '1;
            r_sckPrev  <= 1'b0;
        end else begin
            r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], spi_sck};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi};
            r_csSync   <= {r_csSync[SYNC_STAGES-2:0], spi_cs};
            r_sckPrev  <= w_sck;
        end
    end

    assign w_sck      = r_sckSync[SYNC_STAGES-1];
    assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
    assign w_cs       = r_csSync[SYNC_STAGES-1];
    assign w_sckRise  = w_sck & ~r_sckPrev;

    // A cs rise in SHIFT takes priority over any sck edge arriving in the same cycle
    assign w_csRise   = (r_state == SHIFT) & w_cs;
    assign w_shiftEn  = (r_state == SHIFT) & ~w_cs & w_sckRise;
    assign w_wordDone = w_shiftEn & (r_bitCnt == LAST_BIT);

    // Shift direction decides which end of the word the first bit ends up in
    generate
        if (LSB_FIRST) begin : g_lsbFirst
            assign w_word = {w_mosi, r_shift[WIDTH-1:1]};
        end else begin : g_msbFirst
            assign w_word = {r_shift[WIDTH-2:0], w_mosi};
        end
    endgenerate

    // Frame state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Frame state follows the synchronized chip select
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (!w_cs) w_stateNext = SHIFT;
            SHIFT:   if (w_cs)  w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Bit counter and shift register; cleared while idle and when a frame ends
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitCnt <= '0;
            r_shift  <= '0;
        end else if ((r_state == IDLE) || w_csRise) begin
            r_bitCnt <= '0;
            r_shift  <= '0;
        end else if (w_shiftEn) begin
            r_shift  <= w_word;
            r_bitCnt <= w_wordDone ? '0 : (r_bitCnt + CNT_W'(1));
        end
    end

    // Flag a frame that ended with a partial word pending
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frameErr <= 1'b0;
        end else begin
            r_frameErr <= w_csRise && (r_bitCnt != '0);
        end
    end

    // Holding register with valid/ready handshake; a word arriving into a full, unread register is dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rxData  <= '0;
            r_rxValid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_wordDone) begin
                if (!r_rxValid || rx_ready) begin
                    r_rxData  <= w_word;
                    r_rxValid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rxValid && rx_ready) begin
                r_rxValid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rxData;
    assign rx_valid  = r_rxValid;
    assign overrun   = r_overrun;
    assign frame_err = r_frameErr;

endmodule

// File: tb/tb_spi_tft_rx.sv
// tb_spi_tft_rx: bench for spi_tft_rx. Drives an LSB-first and an MSB-first instance
// from the same SPI stream and compares both against a frame-level model every cycle.
module tb_spi_tft_rx;

    localparam int W    = 16;
    localparam int HALF = 4;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          sck     = 1'b0;
    logic          mosi    = 1'b0;
    logic          cs      = 1'b1;
    logic          rxReady = 1'b0;

    logic [W-1:0]  dataLsb;
    logic [W-1:0]  dataMsb;
    logic          validLsb;
    logic          validMsb;
    logic          ovLsb;
    logic          ovMsb;
    logic          ferrLsb;
    logic          ferrMsb;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;

    bit            modelBits[$];
    logic [W-1:0]  wordAt[int];
    bit            ferrAt[int];
    logic          expValid = 1'b0;
    logic [W-1:0]  expData  = '0;
    logic          expOv    = 1'b0;
    logic          expFerr  = 1'b0;

    int            validCount    = 0;
    int            validLowCount = 0;
    int            ovCount       = 0;
    int            ferrCount     = 0;
    int            firstValidCyc = -1;
    logic [W-1:0]  capDataLsb    = '0;
    logic [W-1:0]  capDataMsb    = '0;
    int            startCyc;

    spi_tft_rx #(.WIDTH(W), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) dutLsb (
        .clk(clk), .reset_n(reset_n), .spi_sck(sck), .spi_mosi(mosi), .spi_cs(cs),
        .rx_data(dataLsb), .rx_valid(validLsb), .rx_ready(rxReady),
        .overrun(ovLsb), .frame_err(ferrLsb)
    );

    spi_tft_rx #(.WIDTH(W), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) dutMsb (
        .clk(clk), .reset_n(reset_n), .spi_sck(sck), .spi_mosi(mosi), .spi_cs(cs),
        .rx_data(dataMsb), .rx_valid(validMsb), .rx_ready(rxReady),
        .overrun(ovMsb), .frame_err(ferrMsb)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] reverseBits(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // One serial bit: 4 clocks low with mosi set up, then 4 clocks high; called at a negedge
    task automatic applyBit(input bit b);
        logic [W-1:0] word;
        mosi = b;
        sck  = 1'b0;
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        modelBits.push_back(b);
        if (modelBits.size() == W) begin
            word = '0;
            for (int k = 0; k < W; k++) word[k] = modelBits[k];
            // final high first sampled at next posedge N, result visible after N+2
            wordAt[cyc + 3] = word;
            modelBits.delete();
        end
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic applyStimulus(input logic [W-1:0] value);
        for (int k = 0; k < W; k++) applyBit(value[k]);
    endtask

    task automatic applyCsLow();
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic applyCsHigh();
        if (modelBits.size() != 0) ferrAt[cyc + 3] = 1'b1;
        modelBits.delete();
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic clearCounts();
        validCount    = 0;
        validLowCount = 0;
        ovCount       = 0;
        ferrCount     = 0;
        firstValidCyc = -1;
    endtask

    // Model of the holding register, advanced on each clock edge from scheduled word/frame events
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            expValid <= 1'b0;
            expData  <= '0;
            expOv    <= 1'b0;
            expFerr  <= 1'b0;
            wordAt.delete();
            ferrAt.delete();
        end else begin
            expOv   <= 1'b0;
            expFerr <= (ferrAt.exists(cyc + 1) != 0);
            if (wordAt.exists(cyc + 1) != 0) begin
                if (!expValid) begin
                    expData  <= wordAt[cyc + 1];
                    expValid <= 1'b1;
                end else if (rxReady) begin
                    expData  <= wordAt[cyc + 1];
                end else begin
                    expOv <= 1'b1;
                end
            end else if (expValid && rxReady) begin
                expValid <= 1'b0;
            end
        end
    end

    // Compare both instances against the model every cycle, and gather pulse statistics
    always @(negedge clk) begin
        #1;
        if (!reset_n) begin
            checkOutput("reset data lsb", dataLsb, 0);
            checkOutput("reset data msb", dataMsb, 0);
            checkOutput("reset valid", {validLsb, validMsb}, 0);
            checkOutput("reset overrun", {ovLsb, ovMsb}, 0);
            checkOutput("reset frame_err", {ferrLsb, ferrMsb}, 0);
        end else begin
            checkOutput("data lsb", dataLsb, expData);
            checkOutput("data msb", dataMsb, reverseBits(expData));
            checkOutput("valid lsb", validLsb, expValid);
            checkOutput("valid msb", validMsb, expValid);
            checkOutput("overrun lsb", ovLsb, expOv);
            checkOutput("overrun msb", ovMsb, expOv);
            checkOutput("frame_err lsb", ferrLsb, expFerr);
            checkOutput("frame_err msb", ferrMsb, expFerr);
        end
        if (validLsb) begin
            validCount++;
            capDataLsb = dataLsb;
            capDataMsb = dataMsb;
            if (firstValidCyc < 0) firstValidCyc = cyc;
        end else begin
            validLowCount++;
        end
        if (ovLsb) ovCount++;
        if (ferrLsb) ferrCount++;
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("lit reset data", dataLsb, 16'h0000);
        checkOutput("lit reset valid", validLsb, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single word A55A with consumer always ready
        $display("[TB] single word, both bit orders");
        rxReady = 1'b1;
        applyCsLow();
        clearCounts();
        startCyc = cyc;
        applyStimulus(16'hA55A);
        repeat (4) @(negedge clk);
        checkOutput("lit t1 latency", firstValidCyc - startCyc, 127);
        checkOutput("lit t1 valid cycles", validCount, 1);
        checkOutput("lit t1 data lsb", capDataLsb, 16'hA55A);
        checkOutput("lit t1 data msb", capDataMsb, 16'h5AA5);
        applyCsHigh();

        // Two words with consumer stalled: second is dropped with overrun
        $display("[TB] overrun");
        rxReady = 1'b0;
        applyCsLow();
        clearCounts();
        applyStimulus(16'h1234);
        applyStimulus(16'hBEEF);
        repeat (4) @(negedge clk);
        checkOutput("lit t3 data lsb", dataLsb, 16'h1234);
        checkOutput("lit t3 data msb", dataMsb, 16'h2C48);
        checkOutput("lit t3 valid", validLsb, 1'b1);
        checkOutput("lit t3 overrun pulses", ovCount, 1);
        rxReady = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("lit t3 valid drained", validLsb, 1'b0);
        checkOutput("lit t3 data held", dataLsb, 16'h1234);
        rxReady = 1'b0;
        applyCsHigh();

        // Ready exactly in the cycle the second word completes
        $display("[TB] ready coincident with completion");
        applyCsLow();
        clearCounts();
        applyStimulus(16'h1234);
        validLowCount = 0;
        startCyc = cyc;
        fork
            applyStimulus(16'hBEEF);
            begin
                repeat (126) @(negedge clk);
                rxReady = 1'b1;
                @(negedge clk);
                rxReady = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        checkOutput("lit t4 overrun pulses", ovCount, 0);
        checkOutput("lit t4 data", dataLsb, 16'hBEEF);
        checkOutput("lit t4 valid", validLsb, 1'b1);
        checkOutput("lit t4 valid gaps", validLowCount, 0);
        rxReady = 1'b1;
        repeat (2) @(negedge clk);
        applyCsHigh();

        // Partial frame of 7 bits, then a clean frame
        $display("[TB] frame error");
        applyCsLow();
        clearCounts();
        for (int k = 0; k < 7; k++) applyBit(k[0]);
        applyCsHigh();
        checkOutput("lit t5 frame_err pulses", ferrCount, 1);
        checkOutput("lit t5 no valid", validCount, 0);
        applyCsLow();
        applyStimulus(16'h00FF);
        repeat (4) @(negedge clk);
        checkOutput("lit t5 data", capDataLsb, 16'h00FF);
        checkOutput("lit t5 valid cycles", validCount, 1);
        applyCsHigh();
        checkOutput("lit t5 frame_err total", ferrCount, 1);

        // Reset in the middle of a word, then a full frame
        $display("[TB] reset mid-word");
        applyCsLow();
        for (int k = 0; k < 9; k++) applyBit(1'b1);
        reset_n = 1'b0;
        modelBits.delete();
        @(negedge clk);
        checkOutput("lit t6 reset data", dataLsb, 16'h0000);
        checkOutput("lit t6 reset valid", validLsb, 1'b0);
        checkOutput("lit t6 reset overrun", ovLsb, 1'b0);
        checkOutput("lit t6 reset frame_err", ferrLsb, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clearCounts();
        repeat (4) @(negedge clk);
        applyCsHigh();
        applyCsLow();
        applyStimulus(16'hC3C3);
        repeat (4) @(negedge clk);
        applyCsHigh();
        checkOutput("lit t6 data", capDataLsb, 16'hC3C3);
        checkOutput("lit t6 valid cycles", validCount, 1);
        checkOutput("lit t6 frame_err", ferrCount, 0);
        checkOutput("lit t6 overrun", ovCount, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
